// File: rtl/apb_cfg_initiator.sv
// APB3 initiator: turns a single-outstanding request/response handshake into
// SETUP/ACCESS transfers, with wait-state handling, slave-error capture and an access timeout.
//
//   state  | meaning
//   IDLE   | no transfer; REQ_READY high; APB address/data hold last values
//   SETUP  | PSEL high, PENABLE low for exactly one cycle
//   ACCESS | PSEL and PENABLE high until PREADY or timeout
module apb_cfg_initiator #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WRITE,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_WDATA,
    output logic                  RSP_VALID,
    output logic [DATA_WIDTH-1:0] RSP_RDATA,
    output logic                  RSP_ERR,
    output logic                  RSP_TIMEOUT,
    output logic                  BUSY,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Counter is 8 bits because TIMEOUT may be as large as 255.
    localparam bit         TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [7:0] WAIT_TC    = (TIMEOUT > 0) ? 8'(TIMEOUT - 1) : 8'd0;
    localparam logic [7:0] WAIT_MAX   = 8'hFF;

    state_t                state;
    state_t                state_nxt;
    logic [7:0]            wait_cnt;
    logic [7:0]            wait_cnt_nxt;

    logic [ADDR_WIDTH-1:0] paddr_nxt;
    logic                  psel_nxt;
    logic                  penable_nxt;
    logic                  pwrite_nxt;
    logic [DATA_WIDTH-1:0] pwdata_nxt;
    logic                  rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] rsp_rdata_nxt;
    logic                  rsp_err_nxt;
    logic                  rsp_timeout_nxt;
    logic                  busy_nxt;

    assign REQ_READY = (state == IDLE);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            PADDR       <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            RSP_VALID   <= 1'b0;
            RSP_RDATA   <= '0;
            RSP_ERR     <= 1'b0;
            RSP_TIMEOUT <= 1'b0;
            BUSY        <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            PADDR       <= paddr_nxt;
            PSEL        <= psel_nxt;
            PENABLE     <= penable_nxt;
            PWRITE      <= pwrite_nxt;
            PWDATA      <= pwdata_nxt;
            RSP_VALID   <= rsp_valid_nxt;
            RSP_RDATA   <= rsp_rdata_nxt;
            RSP_ERR     <= rsp_err_nxt;
            RSP_TIMEOUT <= rsp_timeout_nxt;
            BUSY        <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        wait_cnt_nxt    = wait_cnt;
        paddr_nxt       = PADDR;
        psel_nxt        = PSEL;
        penable_nxt     = PENABLE;
        pwrite_nxt      = PWRITE;
        pwdata_nxt      = PWDATA;
        rsp_valid_nxt   = 1'b0;
        rsp_rdata_nxt   = RSP_RDATA;
        rsp_err_nxt     = RSP_ERR;
        rsp_timeout_nxt = RSP_TIMEOUT;

        case (state)
            IDLE: begin
                if (REQ_VALID) begin
                    paddr_nxt   = REQ_ADDR;
                    pwrite_nxt  = REQ_WRITE;
                    pwdata_nxt  = REQ_WDATA;
                    psel_nxt    = 1'b1;
                    penable_nxt = 1'b0;
                    state_nxt   = SETUP;
                end
            end
            SETUP: begin
                penable_nxt  = 1'b1;
                wait_cnt_nxt = '0;
                state_nxt    = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    psel_nxt        = 1'b0;
                    penable_nxt     = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_err_nxt     = PSLVERR;
                    rsp_timeout_nxt = 1'b0;
                    rsp_rdata_nxt   = (!PWRITE && !PSLVERR) ? PRDATA : '0;
                    state_nxt       = IDLE;
                end else if (TIMEOUT_EN && (wait_cnt == WAIT_TC)) begin
                    psel_nxt        = 1'b0;
                    penable_nxt     = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_err_nxt     = 1'b1;
                    rsp_timeout_nxt = 1'b1;
                    rsp_rdata_nxt   = '0;
                    state_nxt       = IDLE;
                end else if (wait_cnt != WAIT_MAX) begin
                    // Saturate so a disabled timeout can wait forever without wrapping.
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            default: begin
                psel_nxt    = 1'b0;
                penable_nxt = 1'b0;
                state_nxt   = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_apb_cfg_initiator.sv
// Directed bench for apb_cfg_initiator: one instance with TIMEOUT=16 and one with the timeout disabled.
module tb_apb_cfg_initiator;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;

    logic       req_valid = 0, req_write = 0;
    logic [4:0] req_addr = '0;
    logic [7:0] req_wdata = '0, prdata = '0;
    logic       pready = 0, pslverr = 0;
    logic       req_ready, rsp_valid, rsp_err, rsp_timeout, busy, psel, penable, pwrite;
    logic [7:0] rsp_rdata, pwdata;
    logic [4:0] paddr;

    logic       req_valid0 = 0, pready0 = 0;
    logic       req_ready0, rsp_valid0, rsp_err0, rsp_timeout0, busy0, psel0, penable0, pwrite0;
    logic [7:0] rsp_rdata0, pwdata0;
    logic [4:0] paddr0;

    int passes = 0;
    int total  = 0;

    always #5 PCLK = ~PCLK;

    apb_cfg_initiator #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WRITE(req_write),
        .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
        .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
        .RSP_TIMEOUT(rsp_timeout), .BUSY(busy),
        .PADDR(paddr), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata),
        .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
    );

    apb_cfg_initiator #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .TIMEOUT(0)) dut0 (
        .PCLK(PCLK), .PRESET(PRESET),
        .REQ_VALID(req_valid0), .REQ_READY(req_ready0), .REQ_WRITE(1'b0),
        .REQ_ADDR(5'h07), .REQ_WDATA(8'h00),
        .RSP_VALID(rsp_valid0), .RSP_RDATA(rsp_rdata0), .RSP_ERR(rsp_err0),
        .RSP_TIMEOUT(rsp_timeout0), .BUSY(busy0),
        .PADDR(paddr0), .PSEL(psel0), .PENABLE(penable0), .PWRITE(pwrite0), .PWDATA(pwdata0),
        .PRDATA(8'h5A), .PREADY(pready0), .PSLVERR(1'b0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic request(input logic wr, input logic [4:0] a, input logic [7:0] d);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
    endtask

    initial begin
        int access_cycles;
        int rsp_seen;

        #2;
        check("rst_req_ready", req_ready, 1);
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        tick();
        tick();
        PRESET = 1'b0;

        // 1: write, no wait states
        pready = 1'b1;
        request(1'b1, 5'h08, 8'h55);
        tick();
        req_valid = 1'b0;
        check("t1_setup_psel", psel, 1);
        check("t1_setup_penable", penable, 0);
        check("t1_paddr", paddr, 5'h08);
        check("t1_pwdata", pwdata, 8'h55);
        check("t1_pwrite", pwrite, 1);
        check("t1_req_ready_busy", req_ready, 0);
        check("t1_busy", busy, 1);
        tick();
        check("t1_access_psel", psel, 1);
        check("t1_access_penable", penable, 1);
        check("t1_access_rsp_valid", rsp_valid, 0);
        tick();
        check("t1_rsp_valid", rsp_valid, 1);
        check("t1_rsp_err", rsp_err, 0);
        check("t1_rsp_rdata", rsp_rdata, 8'h00);
        check("t1_psel_done", psel, 0);
        check("t1_req_ready_done", req_ready, 1);
        check("t1_busy_done", busy, 0);
        tick();
        check("t1_rsp_one_cycle", rsp_valid, 0);
        check("t1_paddr_hold", paddr, 5'h08);

        // 2: read, then back-to-back read accepted alongside RSP_VALID
        prdata = 8'h0B;
        request(1'b0, 5'h10, 8'h00);
        tick();
        req_valid = 1'b0;
        check("t2_pwrite", pwrite, 0);
        tick();
        tick();
        check("t2_rsp_valid", rsp_valid, 1);
        check("t2_rsp_rdata", rsp_rdata, 8'h0B);
        check("t2_rsp_err", rsp_err, 0);
        request(1'b0, 5'h0C, 8'h00);
        prdata = 8'h3C;
        tick();
        req_valid = 1'b0;
        check("t2b_psel", psel, 1);
        check("t2b_paddr", paddr, 5'h0C);
        check("t2b_rsp_valid_low", rsp_valid, 0);
        check("t2b_rdata_hold", rsp_rdata, 8'h0B);
        tick();
        tick();
        check("t2b_rsp_valid", rsp_valid, 1);
        check("t2b_rsp_rdata", rsp_rdata, 8'h3C);

        // 3: three wait states
        pready = 1'b0;
        prdata = 8'h77;
        request(1'b0, 5'h04, 8'h00);
        tick();
        req_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 4) begin
                pready = 1'b1;
                prdata = 8'hA5;
            end
            check($sformatf("t3_access%0d_psel", i), psel, 1);
            check($sformatf("t3_access%0d_penable", i), penable, 1);
            check($sformatf("t3_access%0d_paddr", i), paddr, 5'h04);
            check($sformatf("t3_access%0d_rsp_valid", i), rsp_valid, 0);
        end
        tick();
        check("t3_rsp_valid", rsp_valid, 1);
        check("t3_rsp_rdata", rsp_rdata, 8'hA5);
        check("t3_psel_done", psel, 0);

        // 4: slave error
        pslverr = 1'b1;
        prdata  = 8'hFF;
        request(1'b0, 5'h02, 8'h00);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        pslverr = 1'b0;
        check("t4_rsp_valid", rsp_valid, 1);
        check("t4_rsp_err", rsp_err, 1);
        check("t4_rsp_timeout", rsp_timeout, 0);
        check("t4_rsp_rdata", rsp_rdata, 8'h00);

        // 5a: timeout after exactly 16 ACCESS cycles
        pready = 1'b0;
        prdata = 8'h99;
        request(1'b0, 5'h1F, 8'h00);
        tick();
        req_valid = 1'b0;
        access_cycles = 0;
        rsp_seen = 0;
        for (int i = 0; i < 40 && rsp_seen == 0; i++) begin
            tick();
            if (rsp_valid) rsp_seen = 1;
            else if (penable) access_cycles++;
        end
        check("t5_rsp_seen", rsp_seen, 1);
        check("t5_access_cycles", access_cycles, 16);
        check("t5_rsp_err", rsp_err, 1);
        check("t5_rsp_timeout", rsp_timeout, 1);
        check("t5_rsp_rdata", rsp_rdata, 8'h00);
        check("t5_psel_after", psel, 0);
        check("t5_penable_after", penable, 0);

        // 5b: timeout disabled, slave stalls 300 cycles
        req_valid0 = 1'b1;
        tick();
        req_valid0 = 1'b0;
        rsp_seen = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (rsp_valid0) rsp_seen++;
        end
        check("t5b_no_abort", rsp_seen, 0);
        check("t5b_psel_held", psel0, 1);
        check("t5b_penable_held", penable0, 1);
        pready0 = 1'b1;
        tick();
        pready0 = 1'b0;
        check("t5b_rsp_valid", rsp_valid0, 1);
        check("t5b_rsp_timeout", rsp_timeout0, 0);
        check("t5b_rsp_rdata", rsp_rdata0, 8'h5A);

        // 6: reset in ACCESS, then a normal write
        request(1'b1, 5'h11, 8'hEE);
        tick();
        req_valid = 1'b0;
        tick();
        check("t6_in_access", penable, 1);
        #2;
        PRESET = 1'b1;
        #1;
        check("t6_async_psel", psel, 0);
        check("t6_async_penable", penable, 0);
        check("t6_req_ready", req_ready, 1);
        tick();
        PRESET = 1'b0;
        rsp_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) rsp_seen++;
            tick();
        end
        check("t6_no_rsp", rsp_seen, 0);
        pready = 1'b1;
        request(1'b1, 5'h00, 8'h3C);
        tick();
        req_valid = 1'b0;
        check("t6_paddr", paddr, 5'h00);
        check("t6_pwdata", pwdata, 8'h3C);
        tick();
        tick();
        check("t6_rsp_valid", rsp_valid, 1);
        check("t6_rsp_err", rsp_err, 0);
        check("t6_rsp_timeout", rsp_timeout, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
